// File: rtl/hs_rr_merge_arbiter_if.sv
// Handshake bundle for hs_rr_merge_arbiter: NUM_IN upstream pull channels plus one downstream pull channel.
// The arbiter takes the slave modport; the producer/consumer environment takes master.
interface hs_rr_merge_arbiter_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
);
  logic [NUM_IN-1:0]            req_l;
  logic [NUM_IN-1:0]            ack_l;
  logic [NUM_IN*DATA_WIDTH-1:0] din;
  logic                         req_r;
  logic                         ack_r;
  logic [DATA_WIDTH-1:0]        dout;
  logic [ID_WIDTH-1:0]          src_id;
  logic [NUM_IN-1:0]            full;

  modport master (
    input  req_l, ack_r, dout, src_id, full,
    output ack_l, din, req_r
  );

  modport slave (
    output req_l, ack_r, dout, src_id, full,
    input  ack_l, din, req_r
  );
endinterface

// File: rtl/hs_rr_merge_arbiter.sv
// Round-robin merge of NUM_IN pull channels into one tagged pull channel, with a 1-entry buffer per input.
// Optional macro HS_RR_MERGE_STATS_EN adds per-input grant counters and an empty-stall counter.
module hs_rr_merge_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  hs_rr_merge_arbiter_if.slave   bus
`ifdef HS_RR_MERGE_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]   grant_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]     req_l_q, req_l_n;
  logic [NUM_IN-1:0]     full_q, full_n;
  logic [DATA_WIDTH-1:0] buf_q [NUM_IN];
  logic [DATA_WIDTH-1:0] buf_n [NUM_IN];
  logic                  ack_r_q, ack_r_n;
  logic [DATA_WIDTH-1:0] dout_q, dout_n;
  logic [ID_WIDTH-1:0]   src_id_q, src_id_n;
  logic [IDX_W-1:0]      last_q, last_n;

  logic                  grant_c;
  logic [IDX_W-1:0]      win_c;

  assign bus.req_l  = req_l_q;
  assign bus.full   = full_q;
  assign bus.ack_r  = ack_r_q;
  assign bus.dout   = dout_q;
  assign bus.src_id = src_id_q;

  // Winner: first full buffer after the last granted index, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] cand;
    grant_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    cand    = '0;
    if (bus.req_r && !ack_r_q && (|full_q)) begin
      for (int unsigned k = 1; k <= NUM_IN; k++) begin
        idx  = (32'(last_q) + k) % NUM_IN;
        cand = IDX_W'(idx);
        if (!grant_c && full_q[cand]) begin
          grant_c = 1'b1;
          win_c   = cand;
        end
      end
    end
  end

  always_comb begin
    req_l_n  = req_l_q;
    full_n   = full_q;
    buf_n    = buf_q;
    ack_r_n  = grant_c;
    dout_n   = dout_q;
    src_id_n = src_id_q;
    last_n   = last_q;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (!full_q[i] && !req_l_q[i]) req_l_n[i] = 1'b1;
      // A fill clears the request, overriding the set above; acks on a full buffer are dropped.
      if (bus.ack_l[i] && !full_q[i]) begin
        buf_n[i]   = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        full_n[i]  = 1'b1;
        req_l_n[i] = 1'b0;
      end
    end
    if (grant_c) begin
      full_n[win_c] = 1'b0;
      dout_n        = buf_q[win_c];
      src_id_n      = ID_WIDTH'(win_c);
      last_n        = win_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_l_q  <= '0;
      full_q   <= '0;
      ack_r_q  <= 1'b0;
      dout_q   <= '0;
      src_id_q <= '0;
      last_q   <= IDX_W'(NUM_IN - 1);
      for (int i = 0; i < int'(NUM_IN); i++) buf_q[i] <= '0;
    end else begin
      req_l_q  <= req_l_n;
      full_q   <= full_n;
      ack_r_q  <= ack_r_n;
      dout_q   <= dout_n;
      src_id_q <= src_id_n;
      last_q   <= last_n;
      for (int i = 0; i < int'(NUM_IN); i++) buf_q[i] <= buf_n[i];
    end
  end

`ifdef HS_RR_MERGE_STATS_EN
  logic [31:0] gcnt_q [NUM_IN];
  logic [31:0] stall_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) gcnt_q[i] <= '0;
    end else begin
      if (bus.req_r && !ack_r_q && (full_q == '0)) stall_q <= stall_q + 32'd1;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (grant_c && (win_c == IDX_W'(i))) gcnt_q[i] <= gcnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(NUM_IN); i++) grant_cnt[i*32 +: 32] = gcnt_q[i];
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_hs_rr_merge_arbiter.sv
// Directed bench for hs_rr_merge_arbiter (NUM_IN=4, DATA_WIDTH=32, ID_WIDTH=2).
module tb_hs_rr_merge_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned WORDS_PER_SRC = 5000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  hs_rr_merge_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

`ifdef HS_RR_MERGE_STATS_EN
  logic [N*32-1:0] grant_cnt;
  logic [31:0]     stall_cnt;
`endif

  hs_rr_merge_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef HS_RR_MERGE_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_sent [N];
    int n_got  [N];
    int exp_src;
    int words;
    int cyc;
    logic seen_ack;
    logic prev_ack;
    logic any_ack;

    rst = 1'b1;
    bus.ack_l = '0;
    bus.din   = '0;
    bus.req_r = 1'b0;

    // Reset then idle
    tick();
    check("rst_req_l",  64'(bus.req_l),  64'h0);
    check("rst_ack_r",  64'(bus.ack_r),  64'h0);
    check("rst_dout",   64'(bus.dout),   64'h0);
    check("rst_src_id", 64'(bus.src_id), 64'h0);
    check("rst_full",   64'(bus.full),   64'h0);
    rst = 1'b0;
    tick();
    check("idle_req_l", 64'(bus.req_l), 64'hF);
    tick();
    check("idle_req_l_held", 64'(bus.req_l), 64'hF);
    check("idle_ack_r", 64'(bus.ack_r), 64'h0);

    // Single source: input 2 delivers 0xAA
    bus.req_r = 1'b1;
    bus.ack_l = 4'b0100;
    bus.din[2*DW +: DW] = 32'h0000_00AA;
    tick();
    bus.ack_l = '0;
    check("single_full",  64'(bus.full),  64'h4);
    check("single_req_l", 64'(bus.req_l), 64'hB);
    check("single_noack", 64'(bus.ack_r), 64'h0);
    tick();
    check("single_ack_r", 64'(bus.ack_r),  64'h1);
    check("single_dout",  64'(bus.dout),   64'hAA);
    check("single_src",   64'(bus.src_id), 64'h2);
    check("single_drain", 64'(bus.full),   64'h0);
    tick();
    check("single_rereq", 64'(bus.req_l), 64'hF);
    check("single_pulse", 64'(bus.ack_r), 64'h0);

    // Empty: req_r held, nothing buffered
    tick(); tick(); tick();
    check("empty_ack_r", 64'(bus.ack_r),  64'h0);
    check("empty_dout",  64'(bus.dout),   64'hAA);
    check("empty_src",   64'(bus.src_id), 64'h2);

    // Move pointer to 3
    bus.ack_l = 4'b1000;
    bus.din[3*DW +: DW] = 32'h33;
    tick();
    bus.ack_l = '0;
    tick();
    check("last3_src",  64'(bus.src_id), 64'h3);
    check("last3_dout", 64'(bus.dout),   64'h33);
    tick(); tick();

    // Wrap: input 1 full, input 0 fills while 1 is granted
    bus.ack_l = 4'b0010;
    bus.din[1*DW +: DW] = 32'h11;
    tick();
    bus.ack_l = 4'b0001;
    bus.din[0*DW +: DW] = 32'h10;
    tick();
    bus.ack_l = '0;
    check("wrap1_ack",  64'(bus.ack_r),  64'h1);
    check("wrap1_src",  64'(bus.src_id), 64'h1);
    check("wrap1_dout", 64'(bus.dout),   64'h11);
    check("wrap1_full", 64'(bus.full),   64'h1);
    tick();
    check("wrap_gap", 64'(bus.ack_r), 64'h0);
    tick();
    check("wrap0_src",  64'(bus.src_id), 64'h0);
    check("wrap0_dout", 64'(bus.dout),   64'h10);

    // Downstream stall with all producers ready
    bus.req_r = 1'b0;
    any_ack = 1'b0;
    for (int i = 0; i < int'(N); i++) bus.din[i*DW +: DW] = 32'(i * 32'h1000 + 32'h77);
    for (int c = 0; c < 20; c++) begin
      bus.ack_l = bus.req_l;
      tick();
      if (c > 0 && bus.ack_r) any_ack = 1'b1;
    end
    bus.ack_l = '0;
    check("stall_no_ack", 64'(any_ack),   64'h0);
    check("stall_req_l",  64'(bus.req_l), 64'h0);
    check("stall_full",   64'(bus.full),  64'hF);
    bus.req_r = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("stall_grant_ack",  64'(bus.ack_r),  64'h1);
      check("stall_grant_src",  64'(bus.src_id), 64'((g + 1) % 4));
      check("stall_grant_dout", 64'(bus.dout),   64'(((g + 1) % 4) * 32'h1000 + 32'h77));
      tick();
    end
    check("stall_empty", 64'(bus.full), 64'h0);

    // Reset mid-operation with full=0101 and ack_r high
    bus.req_r = 1'b0;
    tick();
    bus.ack_l = 4'b0111;
    tick();
    bus.ack_l = '0;
    check("mid_prefill", 64'(bus.full), 64'h7);
    bus.req_r = 1'b1;
    tick();
    check("mid_full_0101", 64'(bus.full),   64'h5);
    check("mid_ack_hi",    64'(bus.ack_r),  64'h1);
    check("mid_src",       64'(bus.src_id), 64'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_full",  64'(bus.full),   64'h0);
    check("mid_rst_ack",   64'(bus.ack_r),  64'h0);
    check("mid_rst_req_l", 64'(bus.req_l),  64'h0);
    check("mid_rst_dout",  64'(bus.dout),   64'h0);
    check("mid_rst_src",   64'(bus.src_id), 64'h0);
`ifdef HS_RR_MERGE_STATS_EN
    check("mid_rst_gcnt",  64'(grant_cnt != '0), 64'h0);
    check("mid_rst_stall", 64'(stall_cnt), 64'h0);
`endif
    rst = 1'b0;
    tick();
    check("mid_rereq", 64'(bus.req_l), 64'hF);
    bus.ack_l = 4'b1111;
    for (int i = 0; i < int'(N); i++) bus.din[i*DW +: DW] = 32'(32'hC0 + i);
    tick();
    bus.ack_l = '0;
    tick();
    check("mid_last3_src",  64'(bus.src_id), 64'h0);
    check("mid_last3_dout", 64'(bus.dout),   64'hC0);

    // Fairness and per-source ordering with always-ready producers
    rst = 1'b1;
    bus.ack_l = '0;
    tick();
    rst = 1'b0;
    bus.req_r = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      n_sent[i] = 0;
      n_got[i]  = 0;
    end
    exp_src  = 0;
    words    = 0;
    seen_ack = 1'b0;
    prev_ack = 1'b0;
    cyc      = 0;
    while (words < int'(N * WORDS_PER_SRC) && cyc < 45000) begin
      tick();
      cyc++;
      if (seen_ack) check("fair_alternate", 64'(bus.ack_r), 64'(!prev_ack));
      if (bus.ack_r) begin
        seen_ack = 1'b1;
        check("fair_src",  64'(bus.src_id), 64'(exp_src));
        check("fair_data", 64'(bus.dout),   64'(32'(exp_src * 32'h100 + n_got[exp_src])));
        n_got[exp_src]++;
        exp_src = (exp_src + 1) % int'(N);
        words++;
      end
      prev_ack = bus.ack_r;
      for (int i = 0; i < int'(N); i++) begin
        bus.ack_l[i] = 1'b0;
        if (bus.req_l[i] && n_sent[i] < int'(WORDS_PER_SRC)) begin
          bus.ack_l[i] = 1'b1;
          bus.din[i*DW +: DW] = 32'(i * 32'h100 + n_sent[i]);
          n_sent[i]++;
        end
      end
    end
    bus.ack_l = '0;
    check("fair_word_count", 64'(words), 64'(N * WORDS_PER_SRC));
`ifdef HS_RR_MERGE_STATS_EN
    check("fair_gcnt0", 64'(grant_cnt[31:0]), 64'(WORDS_PER_SRC));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_rr_merge_arbiter.md
Name: hs_rr_merge_arbiter

Overview:
- Round-robin arbiter that merges NUM_IN upstream req/ack channels onto one downstream req/ack channel.
- Each input has a 1-entry holding buffer that is refilled autonomously using the same pull protocol as async_operator's req_l/ack_l.
- The downstream consumer pulls words one at a time. Each delivered word is tagged with its source index.
- Used to share one operator or out port between several producers in generated dataflow graphs.

Parameters:
- NUM_IN, 4, number of upstream channels (2..16)
- DATA_WIDTH, 32, data word width
- ID_WIDTH, 2, width of source tag; must be >= clog2(NUM_IN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_l  out  NUM_IN  per-input pull request to upstream producer
- ack_l  in  NUM_IN  per-input single-cycle ack from producer; din slice valid in the same cycle
- din  in  NUM_IN*DATA_WIDTH  packed input data; slice i = din[DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
- req_r  in  1  downstream pull request (level)
- ack_r  out  1  single-cycle ack to downstream
- dout  out  DATA_WIDTH  delivered word; registered on the ack_r cycle, held until the next ack_r
- src_id  out  ID_WIDTH  index of the input that supplied dout; same timing as dout
- full  out  NUM_IN  holding-buffer occupancy flags

Behaviour:
- Reset: req_l=0, ack_r=0, dout=0, src_id=0, full=0, rr pointer last=NUM_IN-1.
- Fill side, per input i, every cycle:
  - if ~full[i] & ~req_l[i]: req_l[i]<=1.
  - if ack_l[i] & ~full[i]: buf[i]<=din slice i, full[i]<=1, req_l[i]<=0. The ack clear wins over the set in the same cycle.
  - ack_l[i] while full[i]=1 is a protocol violation: ignored, buffer unchanged.
- Drain side, one grant per cycle:
  - Condition: req_r & ~ack_r & (|full).
  - Winner: first set full[] index scanning last+1, last+2, ... with modulo NUM_IN wrap.
  - On grant: dout<=buf[w], src_id<=w, ack_r<=1, full[w]<=0, last<=w.
  - Otherwise ack_r<=0.
  - ack_r is never high two consecutive cycles, so peak throughput is 1 word per 2 cycles.
- Simultaneous fill and drain of the same index cannot occur: ack_l is only legal while the buffer is empty. Fill and drain of different indices in the same cycle are both performed.
- Latency:
  - ack_l[i] at cycle t with all other buffers empty and req_r high → ack_r at t+1 carrying that word.
  - Re-request: req_l[i] re-asserts at t+2 after a drain at t+1.
- Fairness: with all buffers continuously full, grants cycle 0,1,...,NUM_IN-1,0,... Any input waits at most NUM_IN grants.
- Empty: req_r held with no full buffer → ack_r stays 0 and dout/src_id hold.
- req_r dropped: no grant occurs; buffers keep their data.
- Reset mid-operation: buffered data is discarded, all state returns to reset values the cycle after rst, and req_l re-asserts one cycle after rst deasserts.
- Per-input data order is preserved. Cross-input order is defined only by RR.

Optional Feature:
- Macro: HS_RR_MERGE_STATS_EN.
- With the macro defined:
  - adds output grant_cnt (NUM_IN*32 packed); slice i increments on each grant to input i.
  - adds output stall_cnt (32); counts cycles with req_r=1, ~ack_r, and full==0.
  - Counters wrap at 2^32 and are cleared by rst.
- Without the macro: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst 1 cycle, no acks → next cycle req_l=4'b1111 and held; ack_r=0, dout=0, src_id=0.
- Single source: only input 2 acks with 0x0000_00AA, req_r held → ack_r pulses the following cycle, dout=0xAA, src_id=2, full[2]=0, req_l[2] back to 1 one cycle later.
- Fairness: all four producers always ready (values i*0x100+n), req_r held → src_id sequence 0,1,2,3,0,1,... and ack_r pulses every second cycle. 5000 words per source arrive in increasing order.
- Wrap: last=3, only input 1 full, then input 0 fills → input 1 granted first, then 0.
- Downstream stall: req_r=0 for 20 cycles with all buffers full → no ack_r, req_l=0, full=4'b1111. req_r=1 → four grants in RR order starting after the previous last.
- Reset mid-operation: rst asserted while full=4'b0101 and ack_r high → cycle after, full=0, ack_r=0, last=3. With STATS_EN, grant_cnt and stall_cnt are 0.
